generic_memory_data_dp: RTL

// Two-port, byte-maskable behavioural SRAM model for the NVDLA simulation memory subsystem.
// - Extends the single-port generic data memory with a second independent read/write port.
// - Adds a configurable read-latency pipeline with per-port valid strobes.
// - Adds a post-reset hardware clear engine; the testbench no longer has to preload the array.

---
 rtl/generic_memory_data_dp.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/generic_memory_data_dp.sv
// generic_memory_data_dp
//   Two-port, byte-maskable behavioural SRAM for the simulation memory
//   subsystem. Each port has a configurable read-latency pipeline with a
//   per-read valid strobe. After reset, a clear engine writes INIT_VALUE to
//   every word. Port accesses are ignored while the clear engine runs.
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   init_busy_o                high while the clear engine runs
//   cen?_i / wen?_i            chip enable / write enable, both active-low
//   a?_i, d?_i, ben?_i         word address, write data, active-low byte enables
//   q?_o, qvalid?_o            read data (held between reads) and its one-cycle strobe

// Read pipeline for one port. Slot 0 is loaded on the acceptance edge and
// slot LAT-1 drives the output, so data appears after edge t+LAT-1.
module generic_memory_data_dp_rdpipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rd_i,     // accepted read this edge
  input  logic          xld_i,    // unknown control this edge: poison Q
  input  logic [DW-1:0] rdata_i,
  output logic [DW-1:0] q_o,
  output logic          qvalid_o
);
  logic [LAT-1:0]         vld_q, x_q;
  logic [LAT-1:0][DW-1:0] dat_q;
  logic [LAT:0]           vld_cat, x_cat;
  logic [LAT:0][DW-1:0]   dat_cat;

  // Index 0 is this edge's input; index s+1 is the output of slot s.
  assign vld_cat = {vld_q, rd_i};
  assign x_cat   = {x_q, xld_i};
  assign dat_cat = {dat_q, (xld_i ? {DW{1'bx}} : rdata_i)};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      x_q   <= '0;
      dat_q <= '0;
    end else begin
      for (int s = 0; s < LAT; s++) begin
        vld_q[s] <= vld_cat[s];
        x_q[s]   <= x_cat[s];
        // The output slot loads only when a slot arrives, so Q holds between reads.
        if (s < LAT-1 || vld_cat[s] || x_cat[s]) dat_q[s] <= dat_cat[s];
      end
    end
  end

  // A poisoned slot never carries a valid read.
  assign q_o      = dat_cat[LAT];
  assign qvalid_o = vld_cat[LAT] & ~x_cat[LAT];
endmodule

module generic_memory_data_dp #(
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    BE_WIDTH     = DATA_WIDTH/8,
  parameter int                    READ_LATENCY = 1,
  parameter int                    INIT_ZERO    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_busy_o,
  input  logic                  cena_i,
  input  logic                  wena_i,
  input  logic [ADDR_WIDTH-1:0] aa_i,
  input  logic [DATA_WIDTH-1:0] da_i,
  input  logic [BE_WIDTH-1:0]   bena_i,
  output logic [DATA_WIDTH-1:0] qa_o,
  output logic                  qvalida_o,
  input  logic                  cenb_i,
  input  logic                  wenb_i,
  input  logic [ADDR_WIDTH-1:0] ab_i,
  input  logic [DATA_WIDTH-1:0] db_i,
  input  logic [BE_WIDTH-1:0]   benb_i,
  output logic [DATA_WIDTH-1:0] qb_o,
  output logic                  qvalidb_o
);
  localparam int NUM_WORDS = 2**ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready;
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= (INIT_ZERO != 0) ? S_CLEAR : S_READY;
    else       state_q <= state_d;
  end

  // Next state: the edge that clears the last word also leaves CLEAR.
  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && cnt_q == {ADDR_WIDTH{1'b1}}) state_d = S_READY;
  end

  // Outputs of the FSM
  always_comb begin
    init_busy_o = (state_q == S_CLEAR);
    ready       = !rst_i && (state_q == S_READY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                   cnt_q <= '0;
    else if (state_q == S_CLEAR) cnt_q <= cnt_q + 1'b1;
  end

  // Port decode. Unknown CEN, or unknown WEN on an enabled port, poisons Q
  // and blocks any array update.
  logic xa, xb, rda, rdb, wra, wrb;
  always_comb begin
    xa  = $isunknown(cena_i) || (!cena_i && $isunknown(wena_i));
    xb  = $isunknown(cenb_i) || (!cenb_i && $isunknown(wenb_i));
    rda = ready && !xa && !cena_i &&  wena_i;
    wra = ready && !xa && !cena_i && !wena_i;
    rdb = ready && !xb && !cenb_i &&  wenb_i;
    wrb = ready && !xb && !cenb_i && !wenb_i;
  end

  // Array. Port B is applied before port A so A's bytes win a same-address
  // collision; reads sample mem_q before these updates land (read-first).
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_CLEAR) mem_q[cnt_q] <= INIT_VALUE;
    if (wrb)
      for (int k = 0; k < BE_WIDTH; k++)
        if (!benb_i[k]) mem_q[ab_i][8*k +: 8] <= db_i[8*k +: 8];
    if (wra)
      for (int k = 0; k < BE_WIDTH; k++)
        if (!bena_i[k]) mem_q[aa_i][8*k +: 8] <= da_i[8*k +: 8];
  end

  generic_memory_data_dp_rdpipe #(.DW(DATA_WIDTH), .LAT(READ_LATENCY)) u_pipe_a (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_i     (rda),
    .xld_i    (ready && xa),
    .rdata_i  (mem_q[aa_i]),
    .q_o      (qa_o),
    .qvalid_o (qvalida_o)
  );

  generic_memory_data_dp_rdpipe #(.DW(DATA_WIDTH), .LAT(READ_LATENCY)) u_pipe_b (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_i     (rdb),
    .xld_i    (ready && xb),
    .rdata_i  (mem_q[ab_i]),
    .q_o      (qb_o),
    .qvalid_o (qvalidb_o)
  );
endmodule
